// File: rtl/timer_countdown_nivel2_if.sv
// Keypad/tick inputs and M:SS countdown outputs of the cooking timer.
// Latency: none (wires only).
// Backpressure: none; keys and ticks are level/edge strobes with no handshake.
interface timer_countdown_nivel2_if;
  logic [3:0] D;
  logic       loadn;
  logic       p_1hz;
  logic       enablen;
  logic       clearn;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       zero;
  logic       running;
  logic       done;

  modport master (
    output D, loadn, p_1hz, enablen, clearn,
    input  min_ones, sec_tens, sec_ones, zero, running, done
  );

  modport slave (
    input  D, loadn, p_1hz, enablen, clearn,
    output min_ones, sec_tens, sec_ones, zero, running, done
  );
endinterface

// File: rtl/timer_countdown_nivel2.sv
// BCD M:SS countdown timer: keypad digit entry, 1 Hz decrement, zero/running/done flags.
// Latency: outputs update one clk after the input transition (edge seen and acted on in one clk).
// Backpressure: none; key strokes in RUN and ticks outside RUN are dropped.
module timer_countdown_nivel2 #(
  parameter logic [3:0] SEC_TENS_WRAP = 4'd5,
  parameter logic [3:0] DIGIT_WRAP    = 4'd9
) (
  input  logic                      clk,
  input  logic                      rst,
  timer_countdown_nivel2_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       zero_q, zero_d;
  logic       loadn_q;
  logic       p_1hz_q;

  logic       key_ev;
  logic       tick_ev;
  logic       key_ok;
  logic [3:0] dec_min, dec_tens, dec_ones;
  logic       dec_zero;
  logic       shift_zero;

  // Edge strobes: falling loadn is one key stroke, rising p_1hz is one second.
  assign key_ev  = loadn_q & ~bus.loadn;
  assign tick_ev = ~p_1hz_q & bus.p_1hz;
  assign key_ok  = key_ev && (bus.D <= 4'd9);

  // Shifting in a zero can push the only nonzero digit out of min_ones.
  assign shift_zero = (tens_q == 4'd0) && (ones_q == 4'd0) && (bus.D == 4'd0);

  // One-second BCD borrow chain; sec_tens above 5 simply counts down.
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else begin
      dec_ones = DIGIT_WRAP;
      if (tens_q != 4'd0) begin
        dec_tens = tens_q - 4'd1;
      end else begin
        dec_tens = SEC_TENS_WRAP;
        dec_min  = min_q - 4'd1;
      end
    end
    dec_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
  end

  // Next-state and digit update; clear beats tick beats key.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (!bus.clearn) begin
          min_d  = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (key_ok) begin
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = bus.D;
          if (bus.D != 4'd0) state_d = SET;
        end
      end
      SET: begin
        if (!bus.clearn) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          state_d = IDLE;
        end else begin
          if (key_ok) begin
            min_d  = tens_q;
            tens_d = ones_q;
            ones_d = bus.D;
          end
          // Keep SET strictly nonzero: an all-zero shift result falls back to IDLE.
          if (key_ok && shift_zero) state_d = IDLE;
          else if (!bus.enablen)    state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.clearn) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          state_d = IDLE;
        end else if (tick_ev) begin
          min_d  = dec_min;
          tens_d = dec_tens;
          ones_d = dec_ones;
          if (dec_zero)         state_d = DONE;
          else if (bus.enablen) state_d = SET;
        end else if (bus.enablen) begin
          state_d = SET;
        end
      end
      DONE: begin
        // Digits are already 0:00 here; keys are dropped so IDLE always means zero time.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    zero_d = (min_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd0);
  end

  // State, digits, zero flag and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      zero_q  <= 1'b1;
      loadn_q <= 1'b1;
      p_1hz_q <= 1'b1;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      zero_q  <= zero_d;
      loadn_q <= bus.loadn;
      p_1hz_q <= bus.p_1hz;
    end
  end

  assign bus.min_ones = min_q;
  assign bus.sec_tens = tens_q;
  assign bus.sec_ones = ones_q;
  assign bus.zero     = zero_q;
  assign bus.running  = (state_q == RUN);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_timer_countdown_nivel2.sv
// Directed bench for the countdown timer: entry, countdown, borrow, done, pause, clear, reset.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_timer_countdown_nivel2;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  timer_countdown_nivel2_if bus ();

  timer_countdown_nivel2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SET  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [11:0] exp);
    chk(tag, {4'h0, bus.min_ones, bus.sec_tens, bus.sec_ones}, {4'h0, exp});
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    chk(tag, {14'h0, dut.state_q}, {14'h0, exp});
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic r, input logic d);
    chk(tag, {13'h0, bus.zero, bus.running, bus.done}, {13'h0, z, r, d});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    bus.D     = d;
    bus.loadn = 1'b0;
    step();
    bus.loadn = 1'b1;
    step();
  endtask

  task automatic tick();
    bus.p_1hz = 1'b1;
    step();
    bus.p_1hz = 1'b0;
    step();
  endtask

  task automatic clear();
    bus.clearn = 1'b0;
    step();
    bus.clearn = 1'b1;
    step();
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.D       = 4'd0;
    bus.loadn   = 1'b1;
    bus.p_1hz   = 1'b0;
    bus.enablen = 1'b1;
    bus.clearn  = 1'b1;
    repeat (3) @(negedge clk);
    chk_time("reset_time", 12'h000);
    chk_flags("reset_flags", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Keys 1,3,0 -> 1:30 in SET
    key(4'd1);
    chk_state("key1_set", S_SET);
    key(4'd3);
    key(4'd0);
    chk_time("entry_130", 12'h130);
    chk_state("entry_state", S_SET);
    chk_flags("entry_flags", 1'b0, 1'b0, 1'b0);

    // Run three seconds: 1:30 -> 1:27
    bus.enablen = 1'b0;
    step();
    chk_state("run_state", S_RUN);
    tick();
    tick();
    tick();
    chk_time("count_127", 12'h127);
    chk_flags("count_flags", 1'b0, 1'b1, 1'b0);

    // Pause, clear, load 1:00, run, one tick -> 0:59 (borrow across minute)
    bus.enablen = 1'b1;
    step();
    chk_state("pause_state", S_SET);
    clear();
    chk_time("clear_time", 12'h000);
    chk_state("clear_state", S_IDLE);
    key(4'd1);
    key(4'd0);
    key(4'd0);
    chk_time("entry_100", 12'h100);
    bus.enablen = 1'b0;
    step();
    tick();
    chk_time("borrow_059", 12'h059);

    // Load 0:02, run down to zero, observe single-cycle done
    bus.enablen = 1'b1;
    step();
    clear();
    key(4'd0);
    chk_state("zero_key_idle", S_IDLE);
    key(4'd2);
    chk_time("entry_002", 12'h002);
    bus.enablen = 1'b0;
    step();
    tick();
    chk_time("count_001", 12'h001);
    bus.p_1hz = 1'b1;
    step();
    chk_time("count_000", 12'h000);
    chk_flags("done_pulse", 1'b1, 1'b0, 1'b1);
    bus.p_1hz = 1'b0;
    step();
    chk_flags("done_cleared", 1'b1, 1'b0, 1'b0);
    chk_state("after_done", S_IDLE);
    step();
    chk_state("no_start_at_zero", S_IDLE);

    // 0:45 in RUN: keys ignored; pause holds digits and ignores ticks
    bus.enablen = 1'b1;
    key(4'd4);
    key(4'd5);
    bus.enablen = 1'b0;
    step();
    chk_state("run45_state", S_RUN);
    key(4'd7);
    chk_time("run_key_ignored", 12'h045);
    bus.enablen = 1'b1;
    step();
    chk_flags("pause_flags", 1'b0, 1'b0, 1'b0);
    tick();
    chk_time("pause_tick_ignored", 12'h045);

    // Clear coincident with tick in RUN: clear wins, no done
    bus.enablen = 1'b0;
    step();
    bus.clearn = 1'b0;
    bus.p_1hz  = 1'b1;
    step();
    chk_time("clr_tick_time", 12'h000);
    chk_state("clr_tick_state", S_IDLE);
    chk_flags("clr_tick_flags", 1'b1, 1'b0, 1'b0);
    bus.clearn = 1'b1;
    bus.p_1hz  = 1'b0;
    step();
    chk_flags("clr_no_done", 1'b1, 1'b0, 1'b0);

    // Sec tens above 5 counts down plainly; invalid digit ignored
    bus.enablen = 1'b1;
    key(4'd7);
    key(4'd5);
    key(4'hA);
    chk_time("invalid_key", 12'h075);
    bus.enablen = 1'b0;
    step();
    tick();
    chk_time("count_074", 12'h074);
    tick();
    tick();
    tick();
    tick();
    tick();
    chk_time("count_069", 12'h069);

    // Async reset mid-RUN: outputs return before the next clock edge
    #2;
    rst = 1'b1;
    #1;
    chk_time("async_rst_time", 12'h000);
    chk_flags("async_rst_flags", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_state("post_rst_state", S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
